// File: rtl/instruction_memory_server_if.sv
// Fetch and host-load bus of the instruction memory server.
// Master drives addresses and load traffic, slave returns data.
interface instruction_memory_server_if #(
    parameter int ROM_ADDRESS_WIDTH = 16,
    parameter int INSTRUCTION_WIDTH = 64
);
    logic [ROM_ADDRESS_WIDTH-1:0] ip;
    logic [ROM_ADDRESS_WIDTH-1:0] ip2;
    logic [INSTRUCTION_WIDTH-1:0] instruction1;
    logic [INSTRUCTION_WIDTH-1:0] instruction2;
    logic                         load_start;
    logic [ROM_ADDRESS_WIDTH-1:0] load_address;
    logic [ROM_ADDRESS_WIDTH-1:0] load_count;
    logic [31:0]                  load_data;
    logic                         load_valid;
    logic                         load_ready;
    logic                         load_busy;
    logic                         load_done;

    modport master (
        output ip, ip2, load_start, load_address, load_count,
        output load_data, load_valid,
        input  instruction1, instruction2,
        input  load_ready, load_busy, load_done
    );

    modport slave (
        input  ip, ip2, load_start, load_address, load_count,
        input  load_data, load_valid,
        output instruction1, instruction2,
        output load_ready, load_busy, load_done
    );
endinterface

// File: rtl/instruction_memory_server.sv
// Dual-read-port instruction memory with a host load engine that
// packs pairs of 32-bit host words into 64-bit instructions.
module instruction_memory_server #(
    parameter int ROM_ADDRESS_WIDTH = 16,
    parameter int INSTRUCTION_WIDTH = 64,
    parameter int DEPTH_LOG2        = 10
) (
    input logic                     clk,
    input logic                     rst_n,
    instruction_memory_server_if.slave bus
);
    localparam int AW    = ROM_ADDRESS_WIDTH;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t                         state;
    logic [DEPTH_LOG2-1:0]          ptr;
    logic [AW-1:0]                  remaining;
    logic [31:0]                    lo_word;
    logic [INSTRUCTION_WIDTH-1:0]   mem [DEPTH];

    logic wr_en;
    logic oor1;
    logic oor2;
    logic unused_addr;

    assign wr_en = (state == HI) && bus.load_valid;
    assign oor1  = |bus.ip[AW-1:DEPTH_LOG2];
    assign oor2  = |bus.ip2[AW-1:DEPTH_LOG2];

    // The base address is taken modulo the array size.
    assign unused_addr = ^bus.load_address[AW-1:DEPTH_LOG2];

    // Both read ports register every cycle; out-of-range reads give a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.instruction1 <= '0;
            bus.instruction2 <= '0;
        end else begin
            bus.instruction1 <= oor1 ? '0 : mem[bus.ip[DEPTH_LOG2-1:0]];
            bus.instruction2 <= oor2 ? '0 : mem[bus.ip2[DEPTH_LOG2-1:0]];
        end
    end

    // Array write on the high-word acceptance edge; contents never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr] <= {bus.load_data, lo_word};
        end
    end

    // Load engine with registered ready/busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            lo_word       <= '0;
            bus.load_ready <= 1'b0;
            bus.load_busy  <= 1'b0;
            bus.load_done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.load_start) begin
                        ptr           <= bus.load_address[DEPTH_LOG2-1:0];
                        remaining     <= bus.load_count;
                        bus.load_busy <= 1'b1;
                        if (bus.load_count == '0) begin
                            state         <= DONE;
                            bus.load_done <= 1'b1;
                        end else begin
                            state          <= LO;
                            bus.load_ready <= 1'b1;
                        end
                    end
                end
                LO: begin
                    if (bus.load_valid) begin
                        lo_word <= bus.load_data;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (bus.load_valid) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == AW'(1)) begin
                            state          <= DONE;
                            bus.load_ready <= 1'b0;
                            bus.load_done  <= 1'b1;
                        end else begin
                            state <= LO;
                        end
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    bus.load_done <= 1'b0;
                    bus.load_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_memory_server.sv
// Self-checking bench: word-count level model of the server plus
// directed load/read scenarios with literal expectations.
module tb_instruction_memory_server;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instruction_memory_server_if #(
        .ROM_ADDRESS_WIDTH(16),
        .INSTRUCTION_WIDTH(64)
    ) bus ();

    instruction_memory_server dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    // Reference model: memory image, words collected vs words needed.
    logic [63:0] mm [1024];
    bit          kn [1024];
    logic [63:0] e1, e2;
    bit          k1, k2;
    bit          collecting, done_p;
    int          need, got, base;
    logic [31:0] lo;

    function automatic void rd(input logic [15:0] a, output logic [63:0] v, output bit k);
        if (a >= 16'h0400) begin
            v = '0;
            k = 1;
        end else begin
            v = mm[a[9:0]];
            k = kn[a[9:0]];
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1 = '0; e2 = '0; k1 = 1; k2 = 1;
            collecting = 0; done_p = 0;
        end else begin
            rd(bus.ip, e1, k1);
            rd(bus.ip2, e2, k2);
            if (done_p) begin
                done_p = 0;
            end else if (collecting) begin
                if (bus.load_valid) begin
                    got++;
                    if (got % 2 == 1) begin
                        lo = bus.load_data;
                    end else begin
                        int a;
                        a = (base + got / 2 - 1) % 1024;
                        mm[a] = {bus.load_data, lo};
                        kn[a] = 1;
                        if (got == need) begin
                            collecting = 0;
                            done_p = 1;
                        end
                    end
                end
            end else if (bus.load_start) begin
                base = int'(bus.load_address) % 1024;
                need = 2 * int'(bus.load_count);
                got = 0;
                if (need == 0) done_p = 1;
                else collecting = 1;
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", 64'(bus.load_ready), 64'(collecting));
            chk("busy", 64'(bus.load_busy), 64'(collecting | done_p));
            chk("done", 64'(bus.load_done), 64'(done_p));
            if (k1) chk("instr1", bus.instruction1, e1);
            if (k2) chk("instr2", bus.instruction2, e2);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Starts a load at the current negedge, streams n words with valid
    // held high, and returns on the cycle the done pulse should show.
    task automatic load(input logic [15:0] b, input logic [15:0] c,
                        input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3,
                        input int n);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        bus.load_start = 1; bus.load_address = b; bus.load_count = c;
        step();
        bus.load_start = 0;
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1;
            bus.load_data = w[i];
            step();
        end
        bus.load_valid = 0;
        chk("done_pulse", 64'(bus.load_done), 64'd1);
    endtask

    int rdy_cnt;

    initial begin
        for (int i = 0; i < 1024; i++) kn[i] = 0;
        bus.ip = '0; bus.ip2 = '0;
        bus.load_start = 0; bus.load_address = '0; bus.load_count = '0;
        bus.load_data = '0; bus.load_valid = 0;
        #1 rst_n = 0;
        cmp_en = 1;
        step(); step();
        chk("rst_instr1", bus.instruction1, 64'd0);
        chk("rst_instr2", bus.instruction2, 64'd0);
        chk("rst_ready", 64'(bus.load_ready), 64'd0);
        chk("rst_busy", 64'(bus.load_busy), 64'd0);
        chk("rst_done", 64'(bus.load_done), 64'd0);
        rst_n = 1;
        step();

        load(16'h0010, 16'd2, 32'h11111111, 32'h22222222,
             32'h33333333, 32'h44444444, 4);
        step();
        chk("done_once", 64'(bus.load_done), 64'd0);
        bus.ip = 16'h0010; bus.ip2 = 16'h0011;
        step();
        chk("rd_0x10", bus.instruction1, 64'h2222222211111111);
        chk("rd_0x11", bus.instruction2, 64'h4444444433333333);
        bus.ip = 16'h0400;
        step();
        chk("rd_oor", bus.instruction1, 64'd0);

        // Wrap-around load with valid held high from before start.
        bus.load_valid = 1; bus.load_data = 32'hDEADBEEF;
        bus.load_start = 1; bus.load_address = 16'h03FF; bus.load_count = 16'd2;
        step();
        bus.load_start = 0;
        rdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] wv [4];
            wv[0] = 32'hA0000001; wv[1] = 32'hB0000002;
            wv[2] = 32'hC0000003; wv[3] = 32'hD0000004;
            if (bus.load_ready) rdy_cnt++;
            bus.load_data = (k < 4) ? wv[k] : 32'h0;
            if (k == 4) bus.load_valid = 0;
            step();
        end
        bus.load_valid = 0;
        chk("ready_cycles", 64'(rdy_cnt), 64'd4);
        bus.ip = 16'h03FF; bus.ip2 = 16'h0000;
        step();
        chk("rd_0x3ff", bus.instruction1, 64'hB0000002A0000001);
        chk("rd_0x000", bus.instruction2, 64'hD0000004C0000003);

        // Read-first collision at 0x20.
        load(16'h0020, 16'd1, 32'h00000001, 32'h00000002, 0, 0, 2);
        step();
        bus.ip = 16'h0020;
        load(16'h0020, 16'd1, 32'h77777777, 32'h88888888, 0, 0, 2);
        chk("coll_old", bus.instruction1, 64'h0000000200000001);
        step();
        chk("coll_new", bus.instruction1, 64'h8888888877777777);

        // Zero-count load: immediate done, no write.
        bus.load_start = 1; bus.load_address = 16'h0010; bus.load_count = 16'd0;
        step();
        bus.load_start = 0;
        chk("zero_done", 64'(bus.load_done), 64'd1);
        chk("zero_busy", 64'(bus.load_busy), 64'd1);
        chk("zero_ready", 64'(bus.load_ready), 64'd0);
        bus.ip = 16'h0010;
        step();
        chk("zero_idle", 64'(bus.load_busy), 64'd0);
        step();
        chk("zero_nowrite", bus.instruction1, 64'h2222222211111111);

        // Reset in the middle of a load.
        load(16'h0040, 16'd2, 32'h10000001, 32'h10000002,
             32'h10000003, 32'h10000004, 4);
        step();
        bus.load_start = 1; bus.load_address = 16'h0040; bus.load_count = 16'd2;
        step();
        bus.load_start = 0;
        bus.load_valid = 1; bus.load_data = 32'hAAAA0001;
        step();
        bus.load_data = 32'hAAAA0002;
        bus.load_start = 1; bus.load_address = 16'h0100; bus.load_count = 16'd5;
        step();
        bus.load_start = 0;
        bus.load_data = 32'hAAAA0003;
        step();
        bus.load_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 64'(bus.load_busy), 64'd0);
        chk("arst_ready", 64'(bus.load_ready), 64'd0);
        step(); step();
        rst_n = 1;
        step();
        chk("arst_nodone", 64'(bus.load_done), 64'd0);
        bus.ip = 16'h0040; bus.ip2 = 16'h0041;
        step();
        chk("arst_kept", bus.instruction1, 64'hAAAA0002AAAA0001);
        chk("arst_unch", bus.instruction2, 64'h1000000410000003);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
